// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/data output stage from NUM_REQ requesters.
// Optional per-requester grant counters are enabled by defining ARB_GRANT_CNT_EN.
module stream_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SRC_WIDTH  = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
`ifdef ARB_GRANT_CNT_EN
    output logic [NUM_REQ*16-1:0]         grant_cnt,
`endif
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_WIDTH-1:0]          out_src,
    input  logic                          out_ready
);

    typedef enum logic {StEmpty, StFull} state_e;

    localparam logic [SRC_WIDTH:0]   NumReqW = (SRC_WIDTH + 1)'(NUM_REQ);
    localparam logic [SRC_WIDTH-1:0] LastIdx = SRC_WIDTH'(NUM_REQ - 1);

    state_e                state_q, state_d;
    logic [SRC_WIDTH-1:0]  rr_ptr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [SRC_WIDTH-1:0]  out_src_q;

    logic                  load_en;
    logic                  transfer;
    logic [NUM_REQ-1:0]    grant;
    logic [SRC_WIDTH-1:0]  grant_idx;
    logic [SRC_WIDTH:0]    scan_sum;
    logic [SRC_WIDTH-1:0]  scan_idx;
    logic [DATA_WIDTH-1:0] in_word [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign in_word[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign load_en = (state_q == StEmpty) || out_ready;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        transfer  = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (load_en && !sys_rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (SRC_WIDTH + 1)'(k);
                if (scan_sum >= NumReqW) begin
                    scan_sum = scan_sum - NumReqW;
                end
                scan_idx = scan_sum[SRC_WIDTH-1:0];
                if (!transfer && in_valid[scan_idx]) begin
                    transfer        = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                end
            end
        end
    end

    assign in_ready = grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: begin
                if (transfer) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (out_ready && !transfer) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= StEmpty;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            state_q <= state_d;
            if (transfer) begin
                out_data_q <= in_word[grant_idx];
                out_src_q  <= grant_idx;
                rr_ptr_q   <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef ARB_GRANT_CNT_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [15:0] cnt_q;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                cnt_q <= '0;
            end else if (grant[i] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign grant_cnt[i*16 +: 16] = cnt_q;
    end
`endif

endmodule
